fe_prefetch_queue: RTL and testbench

//  Parametrised instruction-fetch front end: a PC sequencer and a synchronous-read instruction ROM

---
 rtl/fe_prefetch_queue.sv | 149 ++++++++++++++
 tb/tb_fe_prefetch_queue.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fe_prefetch_queue.sv
// Instruction-fetch front end: a PC sequencer, a synchronous-read instruction ROM and a
// small prefetch queue of {pc, instr} pairs that presents its head to decode.
module fe_prefetch_queue #(
    parameter int unsigned    IW        = 32,
    parameter int unsigned    AW        = 16,
    parameter int unsigned    MEM_DEPTH = 128,
    parameter int unsigned    DEPTH     = 4,
    parameter logic [AW-1:0]  RESET_PC  = '0,
    parameter string          INIT_FILE = "FE_test.mif"
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          Stall,
    input  logic          Loop,
    input  logic [AW-1:0] PC_in,
    output logic          id_valid,
    output logic [IW-1:0] id_instr,
    output logic [AW-1:0] PC_out
);

    localparam int unsigned IdxW = $clog2(MEM_DEPTH);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    // Elaboration-time sanity checks on the configuration.
    if (DEPTH < 2) begin : g_bad_depth
        $error("fe_prefetch_queue: DEPTH must be at least 2");
    end
    if (INIT_FILE == "") begin : g_bad_init
        $error("fe_prefetch_queue: INIT_FILE must name the ROM image");
    end

    // Instruction ROM; contents come from the init file at configuration time.
    (* ram_init_file = INIT_FILE *) logic [IW-1:0] mem [MEM_DEPTH] = '{default: '0};

    // Queue storage (not reset: contents are only visible while count_q != 0).
    logic [AW-1:0]   q_pc_q    [DEPTH];
    logic [IW-1:0]   q_instr_q [DEPTH];

    logic [AW-1:0]   pc_q, pc_d;
    logic [AW-1:0]   rd_pc_q, rd_pc_d;
    logic            rd_valid_q, rd_valid_d;
    logic [IW-1:0]   mdr_q;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic            push, pop, issue;
    logic            fetch_en;
    logic [AW-1:0]   fetch_addr;
    logic [IdxW-1:0] fetch_idx;
    logic [CntW:0]   occupancy;

    assign id_valid  = (count_q != '0);
    assign push      = rd_valid_q & ~Loop;
    assign pop       = id_valid & ~Stall & ~Loop;
    // Queued plus in-flight entries; a same-edge pop earns no credit.
    assign occupancy = {1'b0, count_q} + (CntW + 1)'(rd_valid_q);
    assign issue     = (occupancy < (CntW + 1)'(DEPTH));
    assign fetch_idx = fetch_addr[IdxW-1:0];

    // Next-state: redirect wins over pop/push; fetch issues whenever there is room.
    always_comb begin
        pc_d       = pc_q;
        rd_pc_d    = rd_pc_q;
        rd_valid_d = 1'b0;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        fetch_en   = 1'b0;
        fetch_addr = pc_q;
        if (Loop) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_en   = 1'b1;
            fetch_addr = PC_in;
        end else begin
            fetch_en = issue;
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
        if (fetch_en) begin
            rd_valid_d = 1'b1;
            rd_pc_d    = fetch_addr;
            pc_d       = fetch_addr + AW'(1);
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            rd_pc_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            rd_pc_q    <= rd_pc_d;
            rd_valid_q <= rd_valid_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Synchronous ROM read into the memory data register.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            mdr_q <= '0;
        end else if (fetch_en) begin
            mdr_q <= mem[fetch_idx];
        end
    end

    // Write the completed fetch at the queue tail.
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            q_pc_q[wr_ptr_q]    <= rd_pc_q;
            q_instr_q[wr_ptr_q] <= mdr_q;
        end
    end

    // Head presentation, forced to zero while the queue is empty.
    always_comb begin
        id_instr = '0;
        PC_out   = '0;
        if (id_valid) begin
            id_instr = q_instr_q[rd_ptr_q];
            PC_out   = q_pc_q[rd_ptr_q];
        end
    end

    // The issue rule must keep the queue from overflowing.
    push_not_full_a : assert property (@(posedge CLOCK_50) disable iff (!reset)
        !(push && count_q == CntW'(DEPTH)));

endmodule

// File: tb/tb_fe_prefetch_queue.sv
// Bench for fe_prefetch_queue: table-driven cycle vectors plus a scoreboarded stall/release run.
module tb_fe_prefetch_queue;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        Stall;
    logic        Loop;
    logic [15:0] PC_in;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [15:0] PC_out;

    int n_vec = 0;
    int n_bad = 0;

    fe_prefetch_queue #(
        .IW(32), .AW(16), .MEM_DEPTH(128), .DEPTH(4), .RESET_PC(16'h0000),
        .INIT_FILE("FE_test.mif")
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .Stall    (Stall),
        .Loop     (Loop),
        .PC_in    (PC_in),
        .id_valid (id_valid),
        .id_instr (id_instr),
        .PC_out   (PC_out)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        loop;
        logic [15:0] pc_in;
        logic        exp_valid;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t          vecs[$];
    logic [15:0]   sb[$];

    function automatic logic [31:0] rom_val(input int idx);
        return 32'hC0DE_0000 + 32'(idx) * 32'd7 + 32'd1;
    endfunction

    function automatic vec_t mk(input logic r, input logic s, input logic l,
                                input logic [15:0] pin, input logic ev, input logic [15:0] epc);
        vec_t v;
        v.rst_n = r; v.stall = s; v.loop = l; v.pc_in = pin;
        v.exp_valid = ev; v.exp_pc = epc;
        return v;
    endfunction

    task automatic check_out(input string name, input logic ev, input logic [15:0] epc);
        logic [48:0] exp_w, act_w;
        logic [15:0] e_pc;
        logic [31:0] e_ins;
        e_pc  = ev ? epc : 16'h0000;
        e_ins = ev ? rom_val(int'(epc[6:0])) : 32'h0;
        exp_w = {ev, e_pc, e_ins};
        act_w = {id_valid, PC_out, id_instr};
        n_vec++;
        if (act_w !== exp_w) begin
            n_bad++;
            $display("FAIL %s: got valid=%b pc=%h instr=%h, want valid=%b pc=%h instr=%h",
                     name, id_valid, PC_out, id_instr, ev, e_pc, e_ins);
        end
    endtask

    initial begin
        reset = 1'b0; Stall = 1'b0; Loop = 1'b0; PC_in = 16'h0;
        #1;
        for (int i = 0; i < 128; i++) dut.mem[i] = rom_val(i);

        // Reset, then a free-running stream: first head appears after the second edge.
        vecs.push_back(mk(0, 0, 0, 16'h0, 0, 16'h0));
        vecs.push_back(mk(0, 0, 0, 16'h0, 0, 16'h0));
        vecs.push_back(mk(1, 0, 0, 16'h0, 0, 16'h0));
        for (int i = 0; i < 20; i++) vecs.push_back(mk(1, 0, 0, 16'h0, 1, 16'(i)));
        // Build three queued entries, then redirect to 0x0040.
        vecs.push_back(mk(1, 1, 0, 16'h0, 1, 16'd19));
        vecs.push_back(mk(1, 1, 0, 16'h0, 1, 16'd19));
        vecs.push_back(mk(1, 0, 1, 16'h0040, 0, 16'h0));
        vecs.push_back(mk(1, 0, 0, 16'h0, 1, 16'h0040));
        vecs.push_back(mk(1, 0, 0, 16'h0, 1, 16'h0041));
        vecs.push_back(mk(1, 0, 0, 16'h0, 1, 16'h0042));
        // Redirect while stalled; head becomes the target and holds.
        vecs.push_back(mk(1, 1, 1, 16'h0010, 0, 16'h0));
        vecs.push_back(mk(1, 1, 0, 16'h0, 1, 16'h0010));
        vecs.push_back(mk(1, 1, 0, 16'h0, 1, 16'h0010));
        vecs.push_back(mk(1, 1, 0, 16'h0, 1, 16'h0010));
        // Reset pulse mid-stream while stalled; restart from RESET_PC.
        vecs.push_back(mk(0, 1, 0, 16'h0, 0, 16'h0));
        vecs.push_back(mk(1, 0, 0, 16'h0, 0, 16'h0));
        vecs.push_back(mk(1, 0, 0, 16'h0, 1, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 16'h0, 1, 16'h0001));
        // ROM index wrap and PC wrap.
        vecs.push_back(mk(1, 0, 1, 16'h007F, 0, 16'h0));
        vecs.push_back(mk(1, 0, 0, 16'h0, 1, 16'h007F));
        vecs.push_back(mk(1, 0, 0, 16'h0, 1, 16'h0080));
        vecs.push_back(mk(1, 0, 1, 16'hFFFF, 0, 16'h0));
        vecs.push_back(mk(1, 0, 0, 16'h0, 1, 16'hFFFF));
        vecs.push_back(mk(1, 0, 0, 16'h0, 1, 16'h0000));

        foreach (vecs[i]) begin
            reset = vecs[i].rst_n;
            Stall = vecs[i].stall;
            Loop  = vecs[i].loop;
            PC_in = vecs[i].pc_in;
            @(posedge CLOCK_50);
            #1;
            check_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
        end

        // Stall saturation: head 0 frozen, queue fills, then release must continue 0,1,2,...
        reset = 1'b1; Loop = 1'b0; PC_in = 16'h0;
        for (int i = 0; i < 12; i++) sb.push_back(16'(i));
        Stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLOCK_50);
            #1;
            check_out($sformatf("stall_hold%0d", i), 1'b1, 16'h0000);
        end
        Stall = 1'b0;
        for (int cyc = 0; cyc < 40 && sb.size() > 0; cyc++) begin
            if (id_valid) begin
                check_out("release_order", 1'b1, sb.pop_front());
            end
            @(posedge CLOCK_50);
            #1;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL release_drain: %0d entries left, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
